// File: rtl/rf_pkg.sv
// +--------------------------------------------------------------------+
// | rf_pkg : shared types and default sizes for the register file       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package rf_pkg;

  localparam int RF_DATA_W   = 16;
  localparam int RF_NUM_REGS = 16;

  typedef enum logic [0:0] {
    RF_INIT = 1'b0,
    RF_RUN  = 1'b1
  } rf_state_e;

  // Index width for a register count; never narrower than one bit.
  function automatic int rf_addr_w(input int num_regs);
    return (num_regs > 1) ? $clog2(num_regs) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rf_scoreboard.sv
// +--------------------------------------------------------------------+
// | rf_scoreboard : per-register busy bits with two post-update lookups |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module rf_scoreboard
  import rf_pkg::*;
#(
  parameter  int NUM_REGS = RF_NUM_REGS,
  parameter  int ZERO_R0  = 0,
  localparam int ADDR_W   = rf_addr_w(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_set_en,
  input  logic [ADDR_W-1:0] i_set_addr,
  input  logic              i_clr_en,
  input  logic [ADDR_W-1:0] i_clr_addr,
  input  logic [ADDR_W-1:0] i_lk_addr_a,
  input  logic [ADDR_W-1:0] i_lk_addr_b,
  output logic              o_busy_a,
  output logic              o_busy_b
);

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_nxt;

  // Set is applied after clear so a freshly issued producer wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (i_clr_en) begin
      w_busy_nxt[i_clr_addr] = 1'b0;
    end
    if (i_set_en) begin
      w_busy_nxt[i_set_addr] = 1'b1;
    end
    if (ZERO_R0 != 0) begin
      w_busy_nxt[0] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign o_busy_a = w_busy_nxt[i_lk_addr_a];
  assign o_busy_b = w_busy_nxt[i_lk_addr_b];

endmodule

`default_nettype wire

// File: rtl/regfile_2r1w_sb.sv
// +--------------------------------------------------------------------+
// | regfile_2r1w_sb : 2R/1W register file, bypass, imm, busy scoreboard |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module regfile_2r1w_sb
  import rf_pkg::*;
#(
  parameter  int DATA_W   = RF_DATA_W,
  parameter  int NUM_REGS = RF_NUM_REGS,
  parameter  int ZERO_R0  = 0,
  localparam int ADDR_W   = rf_addr_w(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr_a,
  input  logic [ADDR_W-1:0] i_rd_addr_b,
  input  logic [DATA_W-1:0] i_imm,
  input  logic              i_imm_sel,
  output logic [DATA_W-1:0] o_rd_data_a,
  output logic [DATA_W-1:0] o_rd_data_b,
  output logic              o_rd_valid,
  output logic              o_busy_a,
  output logic              o_busy_b,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rsv_en,
  input  logic [ADDR_W-1:0] i_rsv_addr,
  output logic              o_ready
);

  localparam logic [ADDR_W:0] c_last_idx = (ADDR_W+1)'(NUM_REGS - 1);
  localparam logic [ADDR_W:0] c_one      = (ADDR_W+1)'(1);

  rf_state_e         r_state;
  rf_state_e         w_state_nxt;
  logic [ADDR_W:0]   r_cnt;
  logic [ADDR_W:0]   w_cnt_nxt;
  logic              w_run;
  logic              w_init_we;

  logic [DATA_W-1:0] r_mem [NUM_REGS];
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_waddr;
  logic [DATA_W-1:0] w_mem_wdata;
  logic              w_wr_drop_r0;

  logic [DATA_W-1:0] w_src_a;
  logic [DATA_W-1:0] w_src_b;
  logic              w_sb_busy_a;
  logic              w_sb_busy_b;

  logic [DATA_W-1:0] r_rd_data_a;
  logic [DATA_W-1:0] r_rd_data_b;
  logic              r_rd_valid;
  logic              r_busy_a;
  logic              r_busy_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RF_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_run       = 1'b0;
    w_init_we   = 1'b0;
    case (r_state)
      RF_INIT: begin
        w_init_we = 1'b1;
        w_cnt_nxt = r_cnt + c_one;
        if (r_cnt == c_last_idx) begin
          w_state_nxt = RF_RUN;
        end
      end
      RF_RUN: begin
        w_run = 1'b1;
      end
      default: begin
        w_state_nxt = RF_INIT;
      end
    endcase
  end

  assign w_wr_drop_r0 = (ZERO_R0 != 0) && (i_wr_addr == '0);

  // The clear sequencer and the functional write share one port so the array maps to RAM.
  assign w_mem_we    = ~rst & (w_init_we | (w_run & i_wr_en & ~w_wr_drop_r0));
  assign w_mem_waddr = w_init_we ? r_cnt[ADDR_W-1:0] : i_wr_addr;
  assign w_mem_wdata = w_init_we ? '0 : i_wr_data;

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_waddr] <= w_mem_wdata;
    end
  end

  always_comb begin
    w_src_a = r_mem[i_rd_addr_a];
    if (i_imm_sel) begin
      w_src_a = i_imm;
    end else if ((ZERO_R0 != 0) && (i_rd_addr_a == '0)) begin
      w_src_a = '0;
    end else if (i_wr_en && (i_wr_addr == i_rd_addr_a)) begin
      w_src_a = i_wr_data;
    end
  end

  always_comb begin
    w_src_b = r_mem[i_rd_addr_b];
    if ((ZERO_R0 != 0) && (i_rd_addr_b == '0)) begin
      w_src_b = '0;
    end else if (i_wr_en && (i_wr_addr == i_rd_addr_b)) begin
      w_src_b = i_wr_data;
    end
  end

  rf_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ZERO_R0  (ZERO_R0)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .i_set_en    (w_run & i_rsv_en),
    .i_set_addr  (i_rsv_addr),
    .i_clr_en    (w_run & i_wr_en),
    .i_clr_addr  (i_wr_addr),
    .i_lk_addr_a (i_rd_addr_a),
    .i_lk_addr_b (i_rd_addr_b),
    .o_busy_a    (w_sb_busy_a),
    .o_busy_b    (w_sb_busy_b)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data_a <= '0;
      r_rd_data_b <= '0;
      r_rd_valid  <= 1'b0;
      r_busy_a    <= 1'b0;
      r_busy_b    <= 1'b0;
    end else if (w_run && i_rd_en) begin
      r_rd_data_a <= w_src_a;
      r_rd_data_b <= w_src_b;
      r_rd_valid  <= 1'b1;
      r_busy_a    <= w_sb_busy_a & ~i_imm_sel;
      r_busy_b    <= w_sb_busy_b;
    end else begin
      r_rd_valid  <= 1'b0;
    end
  end

  assign o_rd_data_a = r_rd_data_a;
  assign o_rd_data_b = r_rd_data_b;
  assign o_rd_valid  = r_rd_valid;
  assign o_busy_a    = r_busy_a;
  assign o_busy_b    = r_busy_b;
  assign o_ready     = (r_state == RF_RUN);

endmodule

`default_nettype wire

// File: tb/tb_regfile_2r1w_sb.sv
// +--------------------------------------------------------------------+
// | tb_regfile_2r1w_sb : plain and zero-r0 instances vs behavioural model|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_regfile_2r1w_sb;

  localparam int NR = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en, imm_sel, wr_en, rsv_en;
  logic [3:0]  ra, rb, wa, sa;
  logic [15:0] imm, wd;

  logic [15:0] rda [2];
  logic [15:0] rdb [2];
  logic        vld [2];
  logic        bsa [2];
  logic        bsb [2];
  logic        rdy [2];

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  regfile_2r1w_sb #(.DATA_W(16), .NUM_REGS(NR), .ZERO_R0(0)) u_dut0 (
    .clk(clk), .rst(rst), .i_rd_en(rd_en), .i_rd_addr_a(ra), .i_rd_addr_b(rb),
    .i_imm(imm), .i_imm_sel(imm_sel), .o_rd_data_a(rda[0]), .o_rd_data_b(rdb[0]),
    .o_rd_valid(vld[0]), .o_busy_a(bsa[0]), .o_busy_b(bsb[0]), .i_wr_en(wr_en),
    .i_wr_addr(wa), .i_wr_data(wd), .i_rsv_en(rsv_en), .i_rsv_addr(sa), .o_ready(rdy[0])
  );

  regfile_2r1w_sb #(.DATA_W(16), .NUM_REGS(NR), .ZERO_R0(1)) u_dut1 (
    .clk(clk), .rst(rst), .i_rd_en(rd_en), .i_rd_addr_a(ra), .i_rd_addr_b(rb),
    .i_imm(imm), .i_imm_sel(imm_sel), .o_rd_data_a(rda[1]), .o_rd_data_b(rdb[1]),
    .o_rd_valid(vld[1]), .o_busy_a(bsa[1]), .o_busy_b(bsb[1]), .i_wr_en(wr_en),
    .i_wr_addr(wa), .i_wr_data(wd), .i_rsv_en(rsv_en), .i_rsv_addr(sa), .o_ready(rdy[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: index k is the instance, k==1 has a hardwired zero register.
  int          m_since = 0;
  logic [15:0] m_mem  [2][NR];
  logic [15:0] m_busy [2];
  logic [15:0] m_da [2];
  logic [15:0] m_db [2];
  logic        m_v  [2];
  logic        m_ba [2];
  logic        m_bb [2];

  function automatic logic [15:0] nbusy(input int k);
    logic [15:0] b;
    b = m_busy[k];
    if (wr_en)  b[wa] = 1'b0;
    if (rsv_en) b[sa] = 1'b1;
    if (k == 1) b[0] = 1'b0;
    return b;
  endfunction

  function automatic logic [15:0] rdval(input int k, input logic [3:0] ad);
    if (k == 1 && ad == 4'd0) return 16'h0000;
    if (wr_en && wa == ad)    return wd;
    return m_mem[k][ad];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_since <= 0;
      for (int k = 0; k < 2; k++) begin
        m_busy[k] <= '0;
        m_da[k] <= '0; m_db[k] <= '0;
        m_v[k]  <= 1'b0; m_ba[k] <= 1'b0; m_bb[k] <= 1'b0;
      end
    end else if (m_since < NR) begin
      m_since <= m_since + 1;
      for (int k = 0; k < 2; k++) begin
        m_v[k] <= 1'b0;
        if (m_since == NR - 1)
          for (int r = 0; r < NR; r++) m_mem[k][r] <= 16'h0000;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        m_busy[k] <= nbusy(k);
        if (wr_en && !(k == 1 && wa == 4'd0)) m_mem[k][wa] <= wd;
        m_v[k] <= rd_en;
        if (rd_en) begin
          m_da[k] <= imm_sel ? imm : rdval(k, ra);
          m_db[k] <= rdval(k, rb);
          m_ba[k] <= imm_sel ? 1'b0 : nbusy(k)[ra];
          m_bb[k] <= nbusy(k)[rb];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("m%0d_ready", k), rdy[k], (m_since >= NR));
        chk($sformatf("m%0d_valid", k), vld[k], m_v[k]);
        chk($sformatf("m%0d_data_a", k), rda[k], m_da[k]);
        chk($sformatf("m%0d_data_b", k), rdb[k], m_db[k]);
        chk($sformatf("m%0d_busy_a", k), bsa[k], m_ba[k]);
        chk($sformatf("m%0d_busy_b", k), bsb[k], m_bb[k]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_en = 0; imm_sel = 0; wr_en = 0; rsv_en = 0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [3:0] b);
    rd_en = 1; ra = a; rb = b;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    wr_en = 1; wa = a; wd = d;
  endtask

  task automatic rsv(input logic [3:0] a);
    rsv_en = 1; sa = a;
  endtask

  task automatic wait_ready(input string tag);
    for (int i = 0; i < NR; i++) begin
      chk({tag, "_ready_low0"}, rdy[0], 0);
      chk({tag, "_ready_low1"}, rdy[1], 0);
      tick();
    end
    chk({tag, "_ready_high0"}, rdy[0], 1);
    chk({tag, "_ready_high1"}, rdy[1], 1);
  endtask

  initial begin
    rst = 1; idle(); ra = 0; rb = 0; wa = 0; sa = 0; imm = 0; wd = 0;
    tick(); tick();
    chk_on = 1'b1;
    chk("rst_valid", vld[0], 0);
    chk("rst_data_a", rda[1], 16'h0000);
    rst = 0;
    wait_ready("init");

    rd(5, 5); tick(); idle();
    chk("r5_valid", vld[0], 1);
    chk("r5_data", rda[0], 16'h0000);

    wr(3, 16'hBEEF); tick(); idle();
    rd(3, 3); tick(); idle();
    chk("r3_a", rda[0], 16'hBEEF);
    chk("r3_b", rdb[1], 16'hBEEF);
    chk("r3_valid", vld[1], 1);
    tick();
    chk("r3_hold_valid", vld[0], 0);
    chk("r3_hold_data", rdb[0], 16'hBEEF);

    rsv(7); tick(); idle();
    rd(7, 7); imm_sel = 1; imm = 16'h00FF; tick(); idle();
    chk("imm_data_a", rda[0], 16'h00FF);
    chk("imm_busy_a", bsa[0], 0);
    chk("r7_busy_b", bsb[0], 1);
    wr(7, 16'h1234); rd(7, 7); imm_sel = 1; tick(); idle();
    chk("bypass_b", rdb[0], 16'h1234);
    chk("bypass_busy_b", bsb[0], 0);
    chk("bypass_imm_a", rda[1], 16'h00FF);

    wr(0, 16'hFFFF); tick(); idle();
    rd(0, 0); tick(); idle();
    chk("r0_plain", rda[0], 16'hFFFF);
    chk("r0_zero", rda[1], 16'h0000);
    wr(0, 16'h1111); rd(0, 0); tick(); idle();
    chk("r0_bypass_plain", rdb[0], 16'h1111);
    chk("r0_bypass_zero", rdb[1], 16'h0000);
    rsv(0); tick(); idle();
    rd(0, 0); tick(); idle();
    chk("r0_busy_plain", bsb[0], 1);
    chk("r0_busy_zero", bsb[1], 0);

    rsv(9); tick(); idle();
    rd(1, 9); tick(); idle();
    chk("r9_busy", bsb[0], 1);
    wr(9, 16'h0042); rd(1, 9); tick(); idle();
    chk("r9_wr_data", rdb[0], 16'h0042);
    chk("r9_wr_busy", bsb[0], 0);
    rsv(9); wr(9, 16'h0055); rd(9, 9); tick(); idle();
    chk("r9_set_wins", bsb[1], 1);
    chk("r9_set_data", rda[1], 16'h0055);
    rd(9, 9); tick(); idle();
    chk("r9_still_busy", bsa[0], 1);
    rsv(15); rd(15, 15); tick(); idle();
    chk("r15_rsv_same", bsb[0], 1);

    wr(2, 16'hAAAA); tick(); idle();
    rsv(2); tick(); idle();
    rst = 1; tick(); rst = 0;
    repeat (6) tick();
    rst = 1; tick(); rst = 0;
    wr(4, 16'h7777); rsv(4); rd(4, 4);
    for (int i = 0; i < NR; i++) begin
      chk("init_ready_low", rdy[1], 0);
      chk("init_valid_low", vld[0], 0);
      if (i == 10) idle();
      tick();
    end
    chk("reinit_ready", rdy[0], 1);
    rd(2, 4); tick(); idle();
    chk("r2_cleared", rda[0], 16'h0000);
    chk("r4_ignored", rdb[0], 16'h0000);
    chk("r2_busy_cleared", bsa[0], 0);
    chk("r4_busy_ignored", bsb[1], 0);
    rd(9, 9); tick(); idle();
    chk("r9_busy_cleared", bsb[0], 0);

    for (int i = 0; i < 400; i++) begin
      rd_en   = ($urandom_range(0, 3) != 0);
      imm_sel = ($urandom_range(0, 3) == 0);
      wr_en   = ($urandom_range(0, 1) == 1);
      rsv_en  = ($urandom_range(0, 2) == 0);
      ra = 4'($urandom_range(0, 15)); rb = 4'($urandom_range(0, 15));
      wa = 4'($urandom_range(0, 15)); sa = 4'($urandom_range(0, 15));
      imm = 16'($urandom); wd = 16'($urandom);
      rst = (i == 200);
      tick();
    end
    rst = 0; idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
